sensor_drive_sequencer: RTL and testbench
=========================================

// Module: sensor_drive_sequencer
// PURPOSE
//  Drives the control inputs of the mt9p031/sony slave sensor model (xclr, xtrig, xhs, xvs, pause_en).
//  Sequences clear release, frame start, per-line sync pulses and vertical blanking.
//  Supports free-run and external-trigger modes, with a pause request honoured at line boundaries.
//  Sits in the testbench top between stimulus control and the sensor model.
// PARAMETERS
//  CLR_CYCLES   16  cycles o_xclr is held low after reset release or i_enable rising edge
//  TRIG_WIDTH   2   o_xtrig high-pulse width, in cycles
//  XHS_WIDTH    4   o_xhs high-pulse width at the start of each line period, in cycles
//  VBLANK_LINE  22  blank line periods appended after iv_height lines
// PORTS
//  clk              in   1   sequencer clock; the same clock as the sensor model
//  reset_n          in   1   asynchronous reset, active-low
//  i_enable         in   1   1 = run sequencer
//  i_free_run       in   1   1 = start the next frame immediately; 0 = wait for a rising edge of i_ext_trig
//  i_ext_trig       in   1   external trigger, synchronous to clk
//  i_pause_req      in   1   pause request
//  iv_line_period   in   16  clocks per line period
//  iv_height        in   16  active lines per frame
//  o_xclr           out  1   sensor clear, active-low
//  o_xtrig          out  1   frame trigger pulse
//  o_xhs            out  1   line sync pulse
//  o_xvs            out  1   one-cycle frame-start marker
//  o_pause_en       out  1   sensor pause
//  o_busy           out  1   high from trigger acceptance until the last line period ends
//  ov_frame_cnt     out  16  completed frames; wraps from 0xFFFF to 0
// BEHAVIOUR
//  Reset values: o_xclr=0, all other 1-bit outputs 0, ov_frame_cnt=0, FSM in S_CLR with the CLR counter cleared.
//  S_CLR:
//   - o_xclr=0 for CLR_CYCLES cycles, then o_xclr=1 and go to S_IDLE.
//   - S_CLR is re-entered from S_IDLE whenever i_enable is detected rising.
//  S_IDLE:
//   - Stay here while i_enable=0.
//   - Accept a frame when i_enable=1 and either i_free_run=1 or i_ext_trig shows 0->1 (registered edge detect).
//   - On acceptance, latch iv_height and iv_line_period, then go to S_TRIG.
//   - If the latched height is 0, drop the trigger and stay in S_IDLE.
//  Line-period clamp: a latched period below XHS_WIDTH+1 is clamped to XHS_WIDTH+1.
//  S_TRIG:
//   - o_xtrig=1 for TRIG_WIDTH cycles.
//   - o_xvs=1 in the first of those cycles.
//   - Then go to S_LINE with line counter=0.
//  S_LINE:
//   - Line timer counts 0..period-1; o_xhs=1 while timer<XHS_WIDTH.
//   - At timer=period-1, increment the line counter.
//   - After height+VBLANK_LINE periods (a 17-bit sum, no overflow), increment ov_frame_cnt and go to S_IDLE.
//   - In free-run the next trigger is accepted on the following cycle, so the frame-to-frame gap is 1 idle cycle.
//   - o_busy=1 throughout S_TRIG and S_LINE.
//  Pause:
//   - i_pause_req is sampled only at timer=period-1.
//   - If it is 1, enter S_PAUSE: o_pause_en=1, timer and line counter frozen, o_xhs=0.
//   - Leave S_PAUSE the cycle after i_pause_req=0, resuming at timer=0 of the next line.
//  Trigger while busy: an i_ext_trig edge in S_TRIG, S_LINE or S_PAUSE is ignored and not queued.
//  i_enable falling mid-frame: the current frame completes, then the FSM stays in S_IDLE.
//  Reset mid-frame: outputs take their reset values immediately; a partial frame is not counted.
//  iv_* changes mid-frame take effect only at the next trigger acceptance.
// CONFIGURATION
//  SENSOR_SEQ_OVERRUN_CNT_EN defined:
//   - Adds ports ov_overrun_cnt (out, 16) and i_overrun_clr (in, 1).
//   - ov_overrun_cnt counts i_ext_trig edges ignored while busy; it saturates at 0xFFFF.
//   - i_overrun_clr=1 clears it synchronously.
//   - If a clear and an ignored edge occur in the same cycle, the result is 0.
//  SENSOR_SEQ_OVERRUN_CNT_EN not defined: neither port exists; dropped triggers are silently discarded.
// STRUCTURE
//  Package sensor_seq_pkg:
//   - state encoding S_CLR/S_IDLE/S_TRIG/S_LINE/S_PAUSE
//   - CNT_W=16
//   - line-total width 17
//  Sub-module sensor_seq_line_timer:
//   - period counter with freeze input
//   - emits o_xhs and a line_end strobe
//  Top: FSM, edge detect, latches, frame counter.
// TESTING
//  T1 reset_n low 5 cycles, then high -> o_xclr=0 for exactly 16 cycles, then 1; no o_xtrig before that.
//  T2 free_run=1, height=4, period=20 -> xtrig 2 cycles wide; 26 xhs pulses each 4 cycles wide, 20 clocks apart; frame_cnt=1 after 2+520 cycles.
//  T3 free_run=0, trig edge during S_LINE -> ignored, no second frame; with SENSOR_SEQ_OVERRUN_CNT_EN, ov_overrun_cnt=1.
//  T4 pause_req=1 mid line 3 -> pause_en rises at the line-3 end; no xhs while paused; resume resets timer; total xhs count still height+22.
//  T5 period=2, XHS_WIDTH=4 -> effective period 5 clocks; height=0 -> no xtrig issued.
//  T6 reset_n low mid-frame with frame_cnt=3 -> all outputs go to reset values asynchronously; frame_cnt=0.

Source files
------------

// File: rtl/sensor_seq_pkg.sv
// -----------------------------------------------------------------------------
// sensor_seq_pkg
// Shared types, timing constants and small helpers for the sensor drive
// sequencer: FSM state encoding, counter widths, clear/trigger/sync pulse
// lengths, and the line-period clamp / frame line-total helpers.
// -----------------------------------------------------------------------------
package sensor_seq_pkg;

    localparam int CNT_W  = 16;
    localparam int LTOT_W = 17;

    typedef enum logic [2:0] {
        S_CLR   = 3'd0,
        S_IDLE  = 3'd1,
        S_TRIG  = 3'd2,
        S_LINE  = 3'd3,
        S_PAUSE = 3'd4
    } seq_state_e;

    localparam logic [4:0]        CLR_CYCLES  = 5'd16;
    localparam logic [1:0]        TRIG_WIDTH  = 2'd2;
    localparam logic [CNT_W-1:0]  XHS_WIDTH   = 16'd4;
    localparam logic [LTOT_W-1:0] VBLANK_LINE = 17'd22;
    // Shortest usable line: the sync pulse plus at least one low cycle.
    localparam logic [CNT_W-1:0]  MIN_PERIOD  = XHS_WIDTH + 16'd1;

    function automatic logic [CNT_W-1:0] clamp_period(input logic [CNT_W-1:0] period);
        return (period < MIN_PERIOD) ? MIN_PERIOD : period;
    endfunction

    // Active lines plus blanking, one bit wider so it can never overflow.
    function automatic logic [LTOT_W-1:0] line_total(input logic [CNT_W-1:0] height);
        return {1'b0, height} + VBLANK_LINE;
    endfunction

endpackage

// File: rtl/sensor_seq_line_timer.sv
// -----------------------------------------------------------------------------
// sensor_seq_line_timer
// Line period counter for the sensor drive sequencer.
//   clk, reset_n : clock, asynchronous active-low reset
//   load         : start a fresh line (timer becomes 0 next cycle)
//   run          : advance the timer; low freezes it
//   hs_en        : the coming cycle belongs to an active line period
//   period       : clocks per line (already clamped)
//   line_end     : strobe, high while the timer sits at period-1 and running
//   xhs          : registered line sync, high for the first XHS_WIDTH clocks
// -----------------------------------------------------------------------------
module sensor_seq_line_timer
    import sensor_seq_pkg::*;
(
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load,
    input  logic             run,
    input  logic             hs_en,
    input  logic [CNT_W-1:0] period,
    output logic             line_end,
    output logic             xhs
);

    logic [CNT_W-1:0] timer_r;
    logic [CNT_W-1:0] timer_nxt_s;
    logic             xhs_r;

    assign line_end = run && (timer_r == (period - 16'd1));

    // Next timer value: restart on load, wrap at line end, hold when frozen.
    always_comb begin
        timer_nxt_s = timer_r;
        if (load) begin
            timer_nxt_s = 16'd0;
        end else if (run) begin
            if (line_end) begin
                timer_nxt_s = 16'd0;
            end else begin
                timer_nxt_s = timer_r + 16'd1;
            end
        end else begin
            timer_nxt_s = timer_r;
        end
    end

    // Timer register and sync pulse, decoded from the next timer value so
    // the pulse is registered yet aligned with the timer.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            timer_r <= 16'd0;
            xhs_r   <= 1'b0;
        end else begin
            timer_r <= timer_nxt_s;
            xhs_r   <= hs_en && (timer_nxt_s < XHS_WIDTH);
        end
    end

    assign xhs = xhs_r;

endmodule

// File: rtl/sensor_drive_sequencer.sv
// -----------------------------------------------------------------------------
// sensor_drive_sequencer
// Drives the sensor model control pins: clear release, frame trigger, per-line
// sync, vertical blanking and pause, in free-run or external-trigger mode.
// Optional feature macro: SENSOR_SEQ_OVERRUN_CNT_EN adds a saturating count of
// trigger edges dropped while busy (ports i_overrun_clr, ov_overrun_cnt).
// Ports:
//   clk, reset_n       clock, asynchronous active-low reset
//   i_enable           run sequencer; a rising edge seen in idle re-clears
//   i_free_run         start frames back to back instead of waiting for trigger
//   i_ext_trig         external trigger, rising edge starts a frame
//   i_pause_req        pause request, honoured at line boundaries
//   iv_line_period     clocks per line (latched at frame start)
//   iv_height          active lines per frame (latched at frame start)
//   o_xclr             sensor clear, active-low
//   o_xtrig, o_xvs     frame trigger pulse and one-cycle frame-start marker
//   o_xhs              line sync pulse
//   o_pause_en         sensor pause
//   o_busy             frame in progress
//   ov_frame_cnt       completed frames, wrapping
// -----------------------------------------------------------------------------
module sensor_drive_sequencer
    import sensor_seq_pkg::*;
(
    input  logic             clk,
    input  logic             reset_n,
    input  logic             i_enable,
    input  logic             i_free_run,
    input  logic             i_ext_trig,
    input  logic             i_pause_req,
    input  logic [CNT_W-1:0] iv_line_period,
    input  logic [CNT_W-1:0] iv_height,
    output logic             o_xclr,
    output logic             o_xtrig,
    output logic             o_xhs,
    output logic             o_xvs,
    output logic             o_pause_en,
    output logic             o_busy,
`ifdef SENSOR_SEQ_OVERRUN_CNT_EN
    input  logic             i_overrun_clr,
    output logic [CNT_W-1:0] ov_overrun_cnt,
`endif
    output logic [CNT_W-1:0] ov_frame_cnt
);

    seq_state_e        state_r;
    logic [4:0]        clr_cnt_r;
    logic [1:0]        trig_cnt_r;
    logic [LTOT_W-1:0] line_cnt_r;
    logic [LTOT_W-1:0] total_r;
    logic [CNT_W-1:0]  per_lat_r;
    logic [CNT_W-1:0]  frame_cnt_r;
    logic              xclr_r, xtrig_r, xvs_r, pause_en_r, busy_r;
    logic              en_d_r, trig_d_r;

    logic en_rise_s, trig_rise_s, accept_s;
    logic trig_done_s, last_line_s, frame_done_s, pause_go_s, resume_s;
    logic load_s, run_s, hs_en_s, line_end_s, xhs_s;

    assign en_rise_s    = i_enable && !en_d_r;
    assign trig_rise_s  = i_ext_trig && !trig_d_r;
    // Enable re-rise wins over a start request in the same cycle.
    assign accept_s     = (state_r == S_IDLE) && !en_rise_s && i_enable &&
                          (i_free_run || trig_rise_s);
    assign trig_done_s  = (state_r == S_TRIG) && (trig_cnt_r == (TRIG_WIDTH - 2'd1));
    assign last_line_s  = ((line_cnt_r + 17'd1) == total_r);
    assign run_s        = (state_r == S_LINE);
    // Frame completion takes priority over a pause request on the last line.
    assign frame_done_s = run_s && line_end_s && last_line_s;
    assign pause_go_s   = run_s && line_end_s && !last_line_s && i_pause_req;
    assign resume_s     = (state_r == S_PAUSE) && !i_pause_req;
    assign load_s       = trig_done_s || resume_s;
    assign hs_en_s      = load_s || (run_s && !frame_done_s && !pause_go_s);

    sensor_seq_line_timer u_line_timer (
        .clk      (clk),
        .reset_n  (reset_n),
        .load     (load_s),
        .run      (run_s),
        .hs_en    (hs_en_s),
        .period   (per_lat_r),
        .line_end (line_end_s),
        .xhs      (xhs_s)
    );

    // Edge-detect history for enable and external trigger.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            en_d_r   <= 1'b0;
            trig_d_r <= 1'b0;
        end else begin
            en_d_r   <= i_enable;
            trig_d_r <= i_ext_trig;
        end
    end

    // Sequencer FSM with its counters, latches and registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r     <= S_CLR;
            clr_cnt_r   <= 5'd0;
            trig_cnt_r  <= 2'd0;
            line_cnt_r  <= 17'd0;
            total_r     <= 17'd0;
            per_lat_r   <= MIN_PERIOD;
            frame_cnt_r <= 16'd0;
            xclr_r      <= 1'b0;
            xtrig_r     <= 1'b0;
            xvs_r       <= 1'b0;
            pause_en_r  <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            xvs_r <= 1'b0;
            case (state_r)
                S_CLR: begin
                    if (clr_cnt_r == (CLR_CYCLES - 5'd1)) begin
                        clr_cnt_r <= 5'd0;
                        xclr_r    <= 1'b1;
                        state_r   <= S_IDLE;
                    end else begin
                        clr_cnt_r <= clr_cnt_r + 5'd1;
                    end
                end
                S_IDLE: begin
                    if (en_rise_s) begin
                        clr_cnt_r <= 5'd0;
                        xclr_r    <= 1'b0;
                        state_r   <= S_CLR;
                    end else if (accept_s) begin
                        per_lat_r <= clamp_period(iv_line_period);
                        total_r   <= line_total(iv_height);
                        // A zero-height request is dropped; stay idle.
                        if (iv_height != 16'd0) begin
                            trig_cnt_r <= 2'd0;
                            xtrig_r    <= 1'b1;
                            xvs_r      <= 1'b1;
                            busy_r     <= 1'b1;
                            state_r    <= S_TRIG;
                        end
                    end
                end
                S_TRIG: begin
                    if (trig_done_s) begin
                        xtrig_r    <= 1'b0;
                        line_cnt_r <= 17'd0;
                        state_r    <= S_LINE;
                    end else begin
                        trig_cnt_r <= trig_cnt_r + 2'd1;
                    end
                end
                S_LINE: begin
                    if (frame_done_s) begin
                        line_cnt_r  <= 17'd0;
                        busy_r      <= 1'b0;
                        frame_cnt_r <= frame_cnt_r + 16'd1;
                        state_r     <= S_IDLE;
                    end else if (line_end_s) begin
                        line_cnt_r <= line_cnt_r + 17'd1;
                        if (pause_go_s) begin
                            pause_en_r <= 1'b1;
                            state_r    <= S_PAUSE;
                        end
                    end
                end
                S_PAUSE: begin
                    if (resume_s) begin
                        pause_en_r <= 1'b0;
                        state_r    <= S_LINE;
                    end
                end
                default: begin
                    state_r <= S_CLR;
                end
            endcase
        end
    end

`ifdef SENSOR_SEQ_OVERRUN_CNT_EN
    logic [CNT_W-1:0] ovr_cnt_r;
    logic             ignored_s;

    assign ignored_s = trig_rise_s &&
                       ((state_r == S_TRIG) || (state_r == S_LINE) || (state_r == S_PAUSE));

    // Saturating count of trigger edges dropped while a frame runs; clear wins.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ovr_cnt_r <= 16'd0;
        end else if (i_overrun_clr) begin
            ovr_cnt_r <= 16'd0;
        end else if (ignored_s && (ovr_cnt_r != 16'hFFFF)) begin
            ovr_cnt_r <= ovr_cnt_r + 16'd1;
        end
    end

    assign ov_overrun_cnt = ovr_cnt_r;
`endif

    assign o_xclr       = xclr_r;
    assign o_xtrig      = xtrig_r;
    assign o_xhs        = xhs_s;
    assign o_xvs        = xvs_r;
    assign o_pause_en   = pause_en_r;
    assign o_busy       = busy_r;
    assign ov_frame_cnt = frame_cnt_r;

endmodule

// File: tb/tb_sensor_drive_sequencer.sv
// -----------------------------------------------------------------------------
// tb_sensor_drive_sequencer
// Self-checking bench: a frame-position model (cycles into the frame, with
// line and timer derived by division) predicts every output each cycle, and
// directed scenarios pin pulse widths, spacings and frame lengths to
// hand-computed numbers. Randomised traffic follows the directed part.
// -----------------------------------------------------------------------------
module tb_sensor_drive_sequencer;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        i_enable = 1'b0, i_free_run = 1'b0, i_ext_trig = 1'b0, i_pause_req = 1'b0;
    logic [15:0] iv_line_period = 16'd0, iv_height = 16'd0;
    logic        o_xclr, o_xtrig, o_xhs, o_xvs, o_pause_en, o_busy;
    logic [15:0] ov_frame_cnt;
`ifdef SENSOR_SEQ_OVERRUN_CNT_EN
    logic        i_overrun_clr = 1'b0;
    logic [15:0] ov_overrun_cnt;
`endif

    always #5 clk = ~clk;

    sensor_drive_sequencer dut (
        .clk(clk), .reset_n(reset_n), .i_enable(i_enable), .i_free_run(i_free_run),
        .i_ext_trig(i_ext_trig), .i_pause_req(i_pause_req),
        .iv_line_period(iv_line_period), .iv_height(iv_height),
        .o_xclr(o_xclr), .o_xtrig(o_xtrig), .o_xhs(o_xhs), .o_xvs(o_xvs),
        .o_pause_en(o_pause_en), .o_busy(o_busy),
`ifdef SENSOR_SEQ_OVERRUN_CNT_EN
        .i_overrun_clr(i_overrun_clr), .ov_overrun_cnt(ov_overrun_cnt),
`endif
        .ov_frame_cnt(ov_frame_cnt)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // A frame is described by m_pos, the number of non-paused cycles since the
    // trigger was accepted: positions 0..1 are the trigger pulse, then
    // total*period line cycles follow.
    int          m_clr_left = 16;
    bit          m_xclr = 1'b0, m_active = 1'b0, m_paused = 1'b0;
    int          m_pos = 0, m_period = 5, m_total = 0;
    logic [15:0] m_frame_cnt = 16'd0, m_ovr = 16'd0;
    bit          m_en_prev = 1'b0, m_trig_prev = 1'b0;

    task automatic model_reset();
        m_clr_left = 16; m_xclr = 1'b0; m_active = 1'b0; m_paused = 1'b0;
        m_pos = 0; m_frame_cnt = 16'd0; m_ovr = 16'd0;
        m_en_prev = 1'b0; m_trig_prev = 1'b0;
    endtask

    task automatic model_step();
        bit en_rise, trig_rise, ignored;
        en_rise = i_enable && !m_en_prev;
        trig_rise = i_ext_trig && !m_trig_prev;
        ignored = 1'b0;
        if (m_clr_left > 0) begin
            m_clr_left--;
            if (m_clr_left == 0) m_xclr = 1'b1;
        end else if (m_active) begin
            ignored = trig_rise;
            if (m_paused) begin
                if (!i_pause_req) m_paused = 1'b0;
            end else begin
                m_pos++;
                if (m_pos - 2 == m_total * m_period) begin
                    m_active = 1'b0;
                    m_frame_cnt = m_frame_cnt + 16'd1;
                end else if (m_pos > 2 && ((m_pos - 2) % m_period) == 0 && i_pause_req) begin
                    m_paused = 1'b1;
                end
            end
        end else if (en_rise) begin
            m_clr_left = 16;
            m_xclr = 1'b0;
        end else if (i_enable && (i_free_run || trig_rise) && iv_height != 16'd0) begin
            m_active = 1'b1; m_paused = 1'b0; m_pos = 0;
            m_period = (iv_line_period < 16'd5) ? 5 : int'(iv_line_period);
            m_total = int'(iv_height) + 22;
        end
`ifdef SENSOR_SEQ_OVERRUN_CNT_EN
        if (i_overrun_clr) m_ovr = 16'd0;
        else if (ignored && m_ovr != 16'hFFFF) m_ovr = m_ovr + 16'd1;
`endif
        m_en_prev = i_enable;
        m_trig_prev = i_ext_trig;
    endtask

    function automatic logic [5:0] model_ctl();
        bit xt, xv, xh;
        xt = m_active && m_pos < 2;
        xv = m_active && m_pos == 0;
        xh = m_active && !m_paused && m_pos >= 2 && ((m_pos - 2) % m_period) < 4;
        return {m_xclr, xt, xh, xv, m_active && m_paused, m_active};
    endfunction

    always @(negedge reset_n) model_reset();
    always @(posedge clk) if (reset_n) model_step();

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        if (reset_n) begin
            check("ctl", {26'd0, o_xclr, o_xtrig, o_xhs, o_xvs, o_pause_en, o_busy}, {26'd0, model_ctl()});
            check("frame_cnt", {16'd0, ov_frame_cnt}, {16'd0, m_frame_cnt});
`ifdef SENSOR_SEQ_OVERRUN_CNT_EN
            check("overrun_cnt", {16'd0, ov_overrun_cnt}, {16'd0, m_ovr});
`endif
        end
    end

    // ---------------- pulse monitor for directed scenarios ----------------
    int cyc = 0;
    int hs_rise, hs_hi, trig_hi, trig_rise, xvs_hi, pause_hi, hs_in_pause, gap_min, gap_max, hs_last;
    logic hs_prev = 1'b0, trig_prev = 1'b0;
    always @(posedge clk) cyc++;

    task automatic mon_clear();
        hs_rise = 0; hs_hi = 0; trig_hi = 0; trig_rise = 0; xvs_hi = 0; pause_hi = 0;
        hs_in_pause = 0; gap_min = 1000000; gap_max = 0; hs_last = -1;
    endtask

    always @(negedge clk) begin
        if (o_xhs === 1'b1 && hs_prev !== 1'b1) begin
            hs_rise++;
            if (hs_last >= 0) begin
                if (cyc - hs_last < gap_min) gap_min = cyc - hs_last;
                if (cyc - hs_last > gap_max) gap_max = cyc - hs_last;
            end
            hs_last = cyc;
        end
        if (o_xhs === 1'b1) hs_hi++;
        if (o_xtrig === 1'b1) trig_hi++;
        if (o_xtrig === 1'b1 && trig_prev !== 1'b1) trig_rise++;
        if (o_xvs === 1'b1) xvs_hi++;
        if (o_pause_en === 1'b1) pause_hi++;
        if (o_pause_en === 1'b1 && o_xhs === 1'b1) hs_in_pause++;
        hs_prev = o_xhs;
        trig_prev = o_xtrig;
    end

    // ---------------- stimulus ----------------
    initial begin
        int k;
        int first_pause;
        mon_clear();
        model_reset();
        i_enable = 1'b1;
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("reset_state", {25'd0, o_xclr, o_xtrig, o_xhs, o_xvs, o_pause_en, o_busy, (ov_frame_cnt != 16'd0)}, 32'd0);
        reset_n = 1'b1;

        // T1: clear held low for 16 cycles after reset release.
        k = 0;
        do begin @(negedge clk); k++; end while (!o_xclr && k < 40);
        #1;
        check("t1_clr_cycles", k, 16);
        check("t1_no_xtrig", trig_rise, 0);

        // T2: free-run single frame, height 4, period 20.
        @(negedge clk); mon_clear();
        iv_height = 16'd4; iv_line_period = 16'd20; i_free_run = 1'b1;
        k = 0;
        do begin @(negedge clk); k++; if (k == 1) i_free_run = 1'b0; end while (o_busy && k < 700);
        #1;
        check("t2_frame_len", k, 523);
        check("t2_frame_cnt", ov_frame_cnt, 1);
        check("t2_xhs_pulses", hs_rise, 26);
        check("t2_xhs_high", hs_hi, 104);
        check("t2_xhs_gap_min", gap_min, 20);
        check("t2_xhs_gap_max", gap_max, 20);
        check("t2_xtrig_width", trig_hi, 2);
        check("t2_xvs_width", xvs_hi, 1);

        // T3: triggered frame with a second edge while busy.
        @(negedge clk); mon_clear();
        iv_height = 16'd2; iv_line_period = 16'd8; i_ext_trig = 1'b1;
        k = 0;
        do begin
            @(negedge clk); k++;
            if (k == 1 || k == 31) i_ext_trig = 1'b0;
            if (k == 30) i_ext_trig = 1'b1;
        end while (o_busy && k < 400);
        check("t3_frame_len", k, 195);
        repeat (20) @(negedge clk);
        #1;
        check("t3_no_second_frame", o_busy, 0);
        check("t3_frame_cnt", ov_frame_cnt, 2);
        check("t3_one_trigger", trig_rise, 1);
`ifdef SENSOR_SEQ_OVERRUN_CNT_EN
        check("t3_overrun", ov_overrun_cnt, 1);
        @(negedge clk); i_overrun_clr = 1'b1;
        @(negedge clk); i_overrun_clr = 1'b0;
        check("t3_overrun_clr", ov_overrun_cnt, 0);
`endif

        // T4: pause requested mid line 3, released 28 cycles later.
        @(negedge clk); mon_clear();
        iv_height = 16'd4; iv_line_period = 16'd20; i_free_run = 1'b1;
        k = 0; first_pause = 0;
        do begin
            @(negedge clk); k++;
            if (k == 1) i_free_run = 1'b0;
            if (k == 72) i_pause_req = 1'b1;
            if (k == 100) i_pause_req = 1'b0;
            if (o_pause_en && first_pause == 0) first_pause = k;
        end while (o_busy && k < 800);
        #1;
        check("t4_pause_start", first_pause, 83);
        check("t4_pause_len", pause_hi, 18);
        check("t4_frame_len", k, 541);
        check("t4_xhs_pulses", hs_rise, 26);
        check("t4_no_xhs_paused", hs_in_pause, 0);
        check("t4_frame_cnt", ov_frame_cnt, 3);

        // T5: period clamp, then zero height.
        @(negedge clk); mon_clear();
        iv_height = 16'd3; iv_line_period = 16'd2; i_free_run = 1'b1;
        k = 0;
        do begin @(negedge clk); k++; if (k == 1) i_free_run = 1'b0; end while (o_busy && k < 300);
        #1;
        check("t5_frame_len", k, 128);
        check("t5_xhs_gap_min", gap_min, 5);
        check("t5_xhs_gap_max", gap_max, 5);
        check("t5_xhs_high", hs_hi, 100);
        @(negedge clk); mon_clear();
        iv_height = 16'd0; i_free_run = 1'b1;
        repeat (30) @(negedge clk);
        i_free_run = 1'b0;
        #1;
        check("t5_h0_no_xtrig", trig_rise, 0);
        check("t5_h0_frame_cnt", ov_frame_cnt, 4);

        // T6: asynchronous reset in the middle of the fourth frame.
        @(negedge clk); reset_n = 1'b0;
        repeat (3) @(negedge clk); reset_n = 1'b1;
        iv_height = 16'd1; iv_line_period = 16'd5; i_free_run = 1'b1;
        k = 0;
        do begin @(negedge clk); k++; end while (ov_frame_cnt != 16'd3 && k < 2000);
        check("t6_reach3", ov_frame_cnt, 3);
        repeat (40) @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        check("t6_async_reset", {25'd0, o_xclr, o_xtrig, o_xhs, o_xvs, o_pause_en, o_busy, (ov_frame_cnt != 16'd0)}, 32'd0);
        check("t6_frame_cnt", ov_frame_cnt, 0);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;

        // Randomised traffic checked each cycle against the model.
        for (int i = 0; i < 6000; i++) begin
            @(negedge clk);
            if ($urandom_range(0, 299) == 0) i_enable = ~i_enable;
            if ($urandom_range(0, 149) == 0) i_free_run = ~i_free_run;
            i_ext_trig = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 39) == 0) i_pause_req = ~i_pause_req;
            if ($urandom_range(0, 49) == 0) iv_height = 16'($urandom_range(0, 3));
            if ($urandom_range(0, 49) == 0) iv_line_period = 16'($urandom_range(0, 9));
`ifdef SENSOR_SEQ_OVERRUN_CNT_EN
            i_overrun_clr = ($urandom_range(0, 199) == 0);
`endif
        end
        @(negedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
